// File: rtl/fpu_addsub_pipe_pkg.sv
// Shared widths, flag indices, special-value classes and stage-register layouts for the FP add/sub pipe.
package fpu_pkg;

  localparam int DEF_EXP_W = 8;
  localparam int DEF_MAN_W = 23;
  localparam int LZ_W      = $clog2(DEF_MAN_W + 6);

  localparam int FLG_INVALID   = 3;
  localparam int FLG_OVERFLOW  = 2;
  localparam int FLG_UNDERFLOW = 1;
  localparam int FLG_INEXACT   = 0;

  typedef enum logic [1:0] {
    SPC_NONE    = 2'd0,
    SPC_QNAN    = 2'd1,
    SPC_INVALID = 2'd2,
    SPC_INF     = 2'd3
  } spc_e;

  // S1 -> S2: operands already swapped (A is the larger magnitude) and B aligned
  typedef struct packed {
    logic                 vld;
    logic                 sign;
    logic                 eff_sub;
    logic [DEF_EXP_W-1:0] exp;
    logic [DEF_MAN_W+3:0] sig_a;
    logic [DEF_MAN_W+3:0] sig_b;
    spc_e                 spc;
  } align_t;

  // S2 -> S3: raw sum {carry, hidden, frac} plus G/R/S and its leading-zero count
  typedef struct packed {
    logic                 vld;
    logic                 sign;
    logic [DEF_EXP_W-1:0] exp;
    logic [DEF_MAN_W+1:0] sig;
    logic [2:0]           grs;
    logic [LZ_W-1:0]      lz;
    spc_e                 spc;
  } stage_t;

  function automatic logic [DEF_EXP_W+DEF_MAN_W:0] qnan(input int ew, input int mw);
    logic [DEF_EXP_W+DEF_MAN_W:0] v;
    v = '0;
    for (int i = 0; i < ew; i++) v[mw + i] = 1'b1;
    v[mw - 1] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/fpu_addsub_pipe_if.sv
// Operand/result channel of the FP add/sub pipe; out_flags exists only with FPU_ADDSUB_FLAGS_EN.
interface fpu_addsub_pipe_if #(
  parameter int EXP_W = fpu_pkg::DEF_EXP_W,
  parameter int MAN_W = fpu_pkg::DEF_MAN_W
);
  logic                   in_valid;
  logic                   in_ready;
  logic                   in_op;
  logic [EXP_W+MAN_W:0]   in_a;
  logic [EXP_W+MAN_W:0]   in_b;
  logic                   out_valid;
  logic                   out_ready;
  logic [EXP_W+MAN_W:0]   out_result;
`ifdef FPU_ADDSUB_FLAGS_EN
  logic [3:0]             out_flags;

  modport master (output in_valid, in_op, in_a, in_b, out_ready,
                  input  in_ready, out_valid, out_result, out_flags);
  modport slave  (input  in_valid, in_op, in_a, in_b, out_ready,
                  output in_ready, out_valid, out_result, out_flags);
`else
  modport master (output in_valid, in_op, in_a, in_b, out_ready,
                  input  in_ready, out_valid, out_result);
  modport slave  (input  in_valid, in_op, in_a, in_b, out_ready,
                  output in_ready, out_valid, out_result);
`endif
endinterface

// File: rtl/fpu_lzc.sv
// Combinational leading-zero counter; an all-zero input returns W.
module fpu_lzc #(
  parameter int W = 28
) (
  input  logic [W-1:0]           din,
  output logic [$clog2(W+1)-1:0] cnt
);
  localparam int CW = $clog2(W + 1);

  always_comb begin
    cnt = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (din[i]) cnt = CW'(W - 1 - i);
    end
  end
endmodule

// File: rtl/fpu_addsub_pipe.sv
// 3-stage FP add/sub (RNE, subnormals, specials), latency 3; every stage freezes while out_valid & ~out_ready.
// Define FPU_ADDSUB_FLAGS_EN to add the pipelined out_flags {invalid,overflow,underflow,inexact}.
module fpu_addsub_pipe
  import fpu_pkg::*;
#(
  parameter int EXP_W = DEF_EXP_W,
  parameter int MAN_W = DEF_MAN_W
) (
  input  logic             clk,
  input  logic             rst,
  fpu_addsub_pipe_if.slave io
);
  localparam int W      = 1 + EXP_W + MAN_W;
  localparam int SUM_W  = MAN_W + 5;
  localparam int SH_MAX = MAN_W + 3;
  localparam int EW2    = EXP_W + 2;

  align_t          s1_d, s1_q;
  stage_t          s2_d, s2_q;
  logic            out_valid_d, out_valid_q;
  logic [W-1:0]    out_result_d, out_result_q;
`ifdef FPU_ADDSUB_FLAGS_EN
  logic [3:0]      flags, out_flags_d, out_flags_q;
`endif
  logic            adv;

  assign adv           = io.out_ready | ~out_valid_q;
  assign io.in_ready   = adv;
  assign io.out_valid  = out_valid_q;
  assign io.out_result = out_result_q;
`ifdef FPU_ADDSUB_FLAGS_EN
  assign io.out_flags  = out_flags_q;
`endif

  // S1: unpack, order by magnitude, align B
  logic                 sa, sb, sl;
  logic [EXP_W-1:0]     ea, eb, el, es, el_eff, es_eff, ediff, sh;
  logic [MAN_W-1:0]     fa, fb, fl, fs;
  logic                 a_nan, b_nan, a_inf, b_inf, swap;
  logic [2*MAN_W+5:0]   b_wide;

  always_comb begin
    sa = io.in_a[W-1];
    ea = io.in_a[W-2 -: EXP_W];
    fa = io.in_a[MAN_W-1:0];
    sb = io.in_b[W-1] ^ io.in_op;
    eb = io.in_b[W-2 -: EXP_W];
    fb = io.in_b[MAN_W-1:0];
    a_nan = (&ea) & (|fa);
    b_nan = (&eb) & (|fb);
    a_inf = (&ea) & ~(|fa);
    b_inf = (&eb) & ~(|fb);
    swap  = {eb, fb} > {ea, fa};
    {sl, el, fl} = swap ? {sb, eb, fb} : {sa, ea, fa};
    {es, fs}     = swap ? {ea, fa} : {eb, fb};
    el_eff = (el == '0) ? EXP_W'(1) : el;
    es_eff = (es == '0) ? EXP_W'(1) : es;
    ediff  = el_eff - es_eff;
    sh     = (ediff > EXP_W'(SH_MAX)) ? EXP_W'(SH_MAX) : ediff;
    // low SH_MAX bits catch everything shifted past R; they collapse into sticky
    b_wide = {(es != '0), fs, 2'b00, {SH_MAX{1'b0}}} >> sh;

    s1_d = s1_q;
    if (adv) begin
      s1_d.vld     = io.in_valid;
      s1_d.sign    = sl;
      s1_d.eff_sub = sa ^ sb;
      s1_d.exp     = el_eff;
      s1_d.sig_a   = {(el != '0), fl, 3'b000};
      s1_d.sig_b   = {b_wide[2*MAN_W+5 -: SH_MAX], |b_wide[SH_MAX-1:0]};
      if (a_nan | b_nan)               s1_d.spc = SPC_QNAN;
      else if (a_inf & b_inf & (sa ^ sb)) s1_d.spc = SPC_INVALID;
      else if (a_inf | b_inf)          s1_d.spc = SPC_INF;
      else                             s1_d.spc = SPC_NONE;
    end
  end

  // S2: significand add/sub and leading-zero count
  logic [SUM_W-1:0] sum;
  logic [LZ_W-1:0]  lz;

  fpu_lzc #(.W(SUM_W)) u_lzc (.din(sum), .cnt(lz));

  always_comb begin
    sum = s1_q.eff_sub ? ({1'b0, s1_q.sig_a} - {1'b0, s1_q.sig_b})
                       : ({1'b0, s1_q.sig_a} + {1'b0, s1_q.sig_b});
    s2_d = s2_q;
    if (adv) begin
      s2_d.vld  = s1_q.vld;
      s2_d.sign = (s1_q.eff_sub && sum == '0) ? 1'b0 : s1_q.sign;
      s2_d.exp  = s1_q.exp;
      s2_d.sig  = sum[SUM_W-1:3];
      s2_d.grs  = sum[2:0];
      s2_d.lz   = lz;
      s2_d.spc  = s1_q.spc;
    end
  end

  // S3: normalise, round to nearest even, pack, override specials
  logic [SUM_W-1:0] full;
  logic [SUM_W-2:0] norm;
  logic [EW2-1:0]   e_in, e_n, e_r, lz_m1, room, lsh;
  logic [MAN_W:0]   mant;
  logic [MAN_W+1:0] mant_r;
  logic [MAN_W-1:0] frac;
  logic             g, r, s, rnd, hid, ovf;
  logic [W-1:0]     res;

  always_comb begin
    full  = {s2_q.sig, s2_q.grs};
    e_in  = EW2'(s2_q.exp);
    lz_m1 = EW2'(s2_q.lz) - EW2'(1);
    room  = e_in - EW2'(1);
    // left shift stops at exponent 1, which leaves a subnormal (gradual underflow)
    lsh   = (lz_m1 < room) ? lz_m1 : room;
    if (s2_q.lz == '0) begin
      norm = {full[SUM_W-1:2], |full[1:0]};
      e_n  = e_in + EW2'(1);
    end else begin
      norm = (SUM_W-1)'(full << lsh);
      e_n  = e_in - lsh;
    end
    mant   = norm[SUM_W-2:3];
    g      = norm[2];
    r      = norm[1];
    s      = norm[0];
    rnd    = g & (r | s | mant[0]);
    mant_r = {1'b0, mant} + (MAN_W+2)'(rnd);
    if (mant_r[MAN_W+1]) begin
      hid  = 1'b1;
      frac = mant_r[MAN_W:1];
      e_r  = e_n + EW2'(1);
    end else begin
      hid  = mant_r[MAN_W];
      frac = mant_r[MAN_W-1:0];
      e_r  = e_n;
    end
    ovf = hid & (e_r >= EW2'((1 << EXP_W) - 1));
    res = {s2_q.sign, {EXP_W{hid}} & e_r[EXP_W-1:0], frac};
    if (ovf) res = {s2_q.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    case (s2_q.spc)
      SPC_QNAN, SPC_INVALID: res = W'(qnan(EXP_W, MAN_W));
      SPC_INF:               res = {s2_q.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      default:               ;
    endcase

`ifdef FPU_ADDSUB_FLAGS_EN
    flags = '0;
    case (s2_q.spc)
      SPC_INVALID: flags[FLG_INVALID] = 1'b1;
      SPC_NONE: begin
        flags[FLG_OVERFLOW]  = ovf;
        flags[FLG_INEXACT]   = g | r | s | ovf;
        flags[FLG_UNDERFLOW] = ~hid & (g | r | s);
      end
      default: ;
    endcase
    out_flags_d = (adv & s2_q.vld) ? flags : out_flags_q;
`endif
    out_valid_d  = adv ? s2_q.vld : out_valid_q;
    out_result_d = (adv & s2_q.vld) ? res : out_result_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q         <= '0;
      s2_q         <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
`ifdef FPU_ADDSUB_FLAGS_EN
      out_flags_q  <= '0;
`endif
    end else begin
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
`ifdef FPU_ADDSUB_FLAGS_EN
      out_flags_q  <= out_flags_d;
`endif
    end
  end

endmodule

// File: tb/tb_fpu_addsub_pipe.sv
// Directed-vector bench for fpu_addsub_pipe (single precision); flag checks only with FPU_ADDSUB_FLAGS_EN.
module tb_fpu_addsub_pipe;

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic [3:0]  f;
  } vec_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  vec_t vt[17];

  fpu_addsub_pipe_if ifc ();

  fpu_addsub_pipe dut (
    .clk (clk),
    .rst (rst),
    .io  (ifc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag, input vec_t v);
    int lat;
    bit seen;
    ifc.in_valid  = 1'b1;
    ifc.in_op     = v.op;
    ifc.in_a      = v.a;
    ifc.in_b      = v.b;
    ifc.out_ready = 1'b1;
    #1;
    check_eq({tag, ":in_ready"}, 64'(ifc.in_ready), 64'd1);
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
    lat  = 1;
    seen = 1'b0;
    while (!seen && lat < 10) begin
      if (ifc.out_valid) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        lat++;
      end
    end
    check_eq({tag, ":latency"}, 64'(lat), 64'd3);
    check_eq({tag, ":result"}, 64'(ifc.out_result), 64'(v.r));
`ifdef FPU_ADDSUB_FLAGS_EN
    check_eq({tag, ":flags"}, 64'(ifc.out_flags), 64'(v.f));
`endif
  endtask

  initial begin
    int sent, recv, t, stalls, extra;
    bit acc, drn;
    n_checks = 0;
    n_fail   = 0;

    //          op    a             b             result        {inv,ovf,unf,inx}
    vt[0]  = '{1'b1, 32'h40400000, 32'h3F800000, 32'h40000000, 4'b0000};
    vt[1]  = '{1'b1, 32'h3F800000, 32'h3F800000, 32'h00000000, 4'b0000};
    vt[2]  = '{1'b1, 32'h3F800000, 32'hBF800000, 32'h40000000, 4'b0000};
    vt[3]  = '{1'b0, 32'h3F800000, 32'h33800000, 32'h3F800000, 4'b0001};
    vt[4]  = '{1'b1, 32'h7F800000, 32'h7F800000, 32'h7FC00000, 4'b1000};
    vt[5]  = '{1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 4'b0101};
    vt[6]  = '{1'b1, 32'h00800000, 32'h00000001, 32'h007FFFFF, 4'b0000};
    vt[7]  = '{1'b0, 32'hBF800000, 32'hBF800000, 32'hC0000000, 4'b0000};
    vt[8]  = '{1'b0, 32'h80000000, 32'h80000000, 32'h80000000, 4'b0000};
    vt[9]  = '{1'b0, 32'h7FC00000, 32'h3F800000, 32'h7FC00000, 4'b0000};
    vt[10] = '{1'b0, 32'hFF800000, 32'h3F800000, 32'hFF800000, 4'b0000};
    vt[11] = '{1'b0, 32'h3F800001, 32'h33800000, 32'h3F800002, 4'b0001};
    vt[12] = '{1'b0, 32'h3F800000, 32'h33C00000, 32'h3F800001, 4'b0001};
    vt[13] = '{1'b1, 32'h00000003, 32'h00000001, 32'h00000002, 4'b0000};
    vt[14] = '{1'b0, 32'h3F800000, 32'h00000001, 32'h3F800000, 4'b0001};
    vt[15] = '{1'b1, 32'h3F800000, 32'h33800000, 32'h3F7FFFFF, 4'b0000};
    vt[16] = '{1'b0, 32'h3F800000, 32'h3F800000, 32'h40000000, 4'b0000};

    rst           = 1'b1;
    ifc.in_valid  = 1'b0;
    ifc.in_op     = 1'b0;
    ifc.in_a      = '0;
    ifc.in_b      = '0;
    ifc.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst:out_valid", 64'(ifc.out_valid), 64'd0);
    check_eq("rst:out_result", 64'(ifc.out_result), 64'd0);
    check_eq("rst:in_ready", 64'(ifc.in_ready), 64'd1);
`ifdef FPU_ADDSUB_FLAGS_EN
    check_eq("rst:out_flags", 64'(ifc.out_flags), 64'd0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 17; i++) run_op($sformatf("v%0d", i), vt[i]);
    @(posedge clk); #1;

    // back-to-back stream, downstream stalls for stream cycles 4..8
    sent   = 0;
    recv   = 0;
    t      = 0;
    stalls = 0;
    while (recv < 6 && t < 60) begin
      ifc.out_ready = !(t >= 4 && t <= 8);
      ifc.in_valid  = (sent < 6);
      if (sent < 6) begin
        ifc.in_op = vt[sent].op;
        ifc.in_a  = vt[sent].a;
        ifc.in_b  = vt[sent].b;
      end
      #1;
      if (ifc.out_valid)
        check_eq($sformatf("stream%0d", recv), 64'(ifc.out_result), 64'(vt[recv].r));
      if (ifc.out_valid && !ifc.out_ready) begin
        stalls++;
        check_eq("stall:in_ready", 64'(ifc.in_ready), 64'd0);
      end
      acc = ifc.in_valid & ifc.in_ready;
      drn = ifc.out_valid & ifc.out_ready;
      @(posedge clk); #1;
      if (acc) sent++;
      if (drn) recv++;
      t++;
    end
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b1;
    check_eq("stream:count", 64'(recv), 64'd6);
    check_eq("stream:stalls", 64'(stalls), 64'd5);
    check_eq("stream:cycles", 64'(t), 64'd14);
    extra = 0;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (ifc.out_valid) extra++;
      @(posedge clk); #1;
    end
    check_eq("stream:no_dup", 64'(extra), 64'd0);

    // reset while ops are in flight
    for (int k = 0; k < 4; k++) begin
      ifc.in_valid = 1'b1;
      ifc.in_op    = vt[k].op;
      ifc.in_a     = vt[k].a;
      ifc.in_b     = vt[k].b;
      @(posedge clk); #1;
    end
    check_eq("pre_rst:out_valid", 64'(ifc.out_valid), 64'd1);
    ifc.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("mid_rst:out_valid", 64'(ifc.out_valid), 64'd0);
    rst   = 1'b0;
    extra = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (ifc.out_valid) extra++;
    end
    check_eq("post_rst:stale", 64'(extra), 64'd0);
    run_op("post_rst:v7", vt[7]);
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
